fp_wb_arbiter: RTL and testbench
================================

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FP register data width.
REQ-002 SHALL have parameter NREQ, default 3, number of writeback requesters (0 = FPU pipe, 1 = FP load, 2 = int-to-FP move).
REQ-003 SHALL use a single clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NREQ, writeback request per requester.
REQ-007 SHALL have port req_ready, output, NREQ, one-hot grant, combinational.
REQ-008 SHALL have port req_addr, input, NREQ*5, destination register, requester i at bits [5i+4:5i].
REQ-009 SHALL have port req_data, input, NREQ*DATA_W, write data, requester i at bits [DATA_W*i +: DATA_W].
REQ-010 SHALL have port we, output, 1, register-file write enable, registered.
REQ-011 SHALL have port waddr, output, 5, register-file write address, registered.
REQ-012 SHALL have port wdata, output, DATA_W, register-file write data, registered.
REQ-013 SHALL have port issue_valid, input, 1, instruction with an FP destination issued this cycle.
REQ-014 SHALL have port issue_rd, input, 5, destination of the issuing instruction.
REQ-015 SHALL have ports q_rs1, q_rs2, q_rd, input, 5 each, hazard-query addresses.
REQ-016 SHALL have ports busy_rs1, busy_rs2, busy_rd, output, 1 each, pending-write status of each query address.
REQ-017 SHALL have port pending, output, 32, scoreboard vector, bit n = f(n) awaits writeback.
REQ-018 SHALL have port flush, input, 1, pipeline flush.

Function
REQ-019 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid=1.
REQ-020 SHALL grant round-robin: the first valid index at or after rr_ptr, searching upward modulo NREQ.
REQ-021 SHALL, on a grant to index g, set rr_ptr to (g+1) mod NREQ on the next edge; rr_ptr is unchanged when there is no grant.
REQ-022 SHALL, for a grant in cycle N, drive we=1 with waddr/wdata equal to the granted req_addr/req_data in cycle N+1; latency is exactly 1 cycle.
REQ-023 SHALL drive we=0 in any cycle following a cycle without a grant; waddr/wdata hold their last values.
REQ-024 SHALL sustain one write per cycle; the output has no back-pressure.
REQ-025 SHALL set pending[issue_rd] on the edge where issue_valid=1.
REQ-026 SHALL clear pending[waddr] on the edge where we=1.
REQ-027 SHALL let the set win when a set and a clear target the same bit on the same edge.
REQ-028 SHALL leave a pending bit set, with no error, when issue_valid targets an already-pending register; WAW avoidance belongs to the issuer via busy_rd.
REQ-029 SHALL drive busy_rs1/busy_rs2/busy_rd = pending[q_rs1/q_rs2/q_rd] combinationally from the registered vector.
REQ-030 SHALL treat all 32 registers, including f0, as ordinary registers.
REQ-031 SHALL, on flush=1, clear pending to 0, force we=0 on the next cycle (squashing that cycle's grant), and deassert all req_ready.
REQ-032 SHALL give flush priority over issue_valid in the same cycle (pending=0 afterwards); rr_ptr is unchanged by flush.

Reset
REQ-033 SHALL, while rst=1, force req_ready=0 and ignore requests, issue_valid and flush.
REQ-034 SHALL reset we=0, waddr=0, wdata=0, pending=0 and rr_ptr=0; busy_* therefore read 0 on the first cycle after reset.
REQ-035 SHALL, on rst asserted mid-operation, discard in-flight grants and scoreboard state so that no write occurs on the cycle after reset.

Verification
REQ-036 SHALL be verified with a single requester: req_valid=001, addr=5, data=16'h3C00 -> req_ready=001 the same cycle; we=1, waddr=5, wdata=16'h3C00 the next cycle, then we=0.
REQ-037 SHALL be verified with contention: all three valid for 6 cycles from reset -> grant order 0,1,2,0,1,2 with one we per cycle.
REQ-038 SHALL be verified for scoreboard set/clear: issue f7 -> pending[7]=1 and busy_rs1=1 (q_rs1=7); requester 0 writes f7 -> pending[7]=0 on the edge where we=1.
REQ-039 SHALL be verified for a same-edge collision: we=1 with waddr=9 and issue_valid=1 with issue_rd=9 -> pending[9] stays 1.
REQ-040 SHALL be verified for flush: pending=0x0000_00F0 with a grant in cycle N and flush in cycle N -> we=0 in N+1 and pending=0.
REQ-041 SHALL be verified for reset mid-stream: rst during continuous grants -> we=0, pending=0, and grant order restarts at requester 0.

Source files
------------

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter: round-robin grant across writeback requesters, a
// one-cycle registered write port, and a 32-entry pending-write scoreboard for hazard checks.
module fp_wb_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREQ   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*5-1:0]      req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic                   we,
    output logic [4:0]             waddr,
    output logic [DATA_W-1:0]      wdata,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rd,
    input  logic [4:0]             q_rs1,
    input  logic [4:0]             q_rs2,
    input  logic [4:0]             q_rd,
    output logic                   busy_rs1,
    output logic                   busy_rs2,
    output logic                   busy_rd,
    output logic [31:0]            pending,
    input  logic                   flush
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              grant_any;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       pending_d;

    // Two passes: indices at/above the pointer first, then the wrapped-around remainder.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        if (rst || flush) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_any && (grant_idx == PTR_W'(i));
            if (grant_idx == PTR_W'(i)) begin
                sel_addr = req_addr[5*i +: 5];
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    assign ptr_next = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // A new issue to the register being written this edge keeps it pending; flush beats both.
    always_comb begin
        pending_d = pending;
        if (we) begin
            pending_d[waddr] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            pending  <= '0;
            rr_ptr_q <= '0;
        end else begin
            we      <= grant_any;
            pending <= pending_d;
            if (grant_any) begin
                waddr    <= sel_addr;
                wdata    <= sel_data;
                rr_ptr_q <= ptr_next;
            end
        end
    end

    assign busy_rs1 = pending[q_rs1];
    assign busy_rs2 = pending[q_rs2];
    assign busy_rd  = pending[q_rd];

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: a reference model predicts grants and scoreboard state,
// and expected writes are queued at grant time and popped when the write port fires.
module tb_fp_wb_arbiter;

    localparam int DATA_W = 16;
    localparam int NREQ   = 3;

    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*5-1:0]      req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   we;
    logic [4:0]             waddr;
    logic [DATA_W-1:0]      wdata;
    logic                   issue_valid;
    logic [4:0]             issue_rd;
    logic [4:0]             q_rs1, q_rs2, q_rd;
    logic                   busy_rs1, busy_rs2, busy_rd;
    logic [31:0]            pending;
    logic                   flush;

    int n_checks = 0;
    int n_pass   = 0;

    wr_t         sb[$];
    int          m_ptr     = 0;
    logic [31:0] m_pending = '0;
    logic        m_we      = 1'b0;
    logic [4:0]  m_waddr   = '0;

    always #5 clk = ~clk;

    fp_wb_arbiter #(
        .DATA_W(DATA_W),
        .NREQ  (NREQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .q_rs1      (q_rs1),
        .q_rs2      (q_rs2),
        .q_rd       (q_rd),
        .busy_rs1   (busy_rs1),
        .busy_rs2   (busy_rs2),
        .busy_rd    (busy_rd),
        .pending    (pending),
        .flush      (flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check the combinational grant, advance the model, then check registered state.
    task automatic tick();
        int              g;
        logic [NREQ-1:0] exp_ready;
        logic [31:0]     nxt;
        wr_t             e;
        #1;
        g = (rst || flush) ? -1 : model_grant(req_valid, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        if (g >= 0) begin
            e.addr = req_addr[5*g +: 5];
            e.data = req_data[DATA_W*g +: DATA_W];
            sb.push_back(e);
            m_ptr = (g + 1) % NREQ;
        end
        if (rst || flush) begin
            nxt = '0;
        end else begin
            nxt = m_pending;
            if (m_we) nxt[m_waddr] = 1'b0;
            if (issue_valid) nxt[issue_rd] = 1'b1;
        end
        if (rst) begin
            sb.delete();
            m_ptr = 0;
        end
        m_pending = nxt;
        m_we      = (g >= 0);
        @(posedge clk);
        #1;
        check("we", we, m_we);
        if (m_we) begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check("waddr", waddr, e.addr);
                check("wdata", wdata, e.data);
                m_waddr = e.addr;
            end
        end
        check("pending", pending, m_pending);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '1;
        req_addr    = {5'd3, 5'd2, 5'd5};
        req_data    = {16'hC000, 16'h4000, 16'h3C00};
        issue_valid = 1'b1;
        issue_rd    = 5'd1;
        flush       = 1'b1;
        q_rs1       = 5'd0;
        q_rs2       = 5'd1;
        q_rd        = 5'd2;
        tick();
        tick();

        rst         = 1'b0;
        req_valid   = '0;
        issue_valid = 1'b0;
        flush       = 1'b0;
        tick();
        check("busy_rs1_rst", busy_rs1, 0);
        check("busy_rs2_rst", busy_rs2, 0);
        check("busy_rd_rst", busy_rd, 0);

        // Single requester: write one cycle after the grant, then idle with held address.
        req_valid = 3'b001;
        tick();
        check("single_waddr", waddr, 5);
        check("single_wdata", wdata, 16'h3C00);
        req_valid = '0;
        tick();
        check("idle_we", we, 0);
        check("idle_waddr_hold", waddr, 5);

        // Contention from reset: 0,1,2,0,1,2.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = '1;
        repeat (6) tick();
        req_valid = '0;
        tick();

        // Scoreboard set and clear of f7.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        q_rs1       = 5'd7;
        #1;
        check("busy_rs1_f7", busy_rs1, 1);
        check("pending_f7_set", pending[7], 1);
        req_addr[4:0] = 5'd7;
        req_valid     = 3'b001;
        tick();
        req_valid = '0;
        tick();
        check("pending_f7_clr", pending[7], 0);
        check("busy_rs1_f7_clr", busy_rs1, 0);

        // Same-edge set and clear of f9: set wins.
        req_addr[4:0] = 5'd9;
        req_valid     = 3'b001;
        tick();
        req_valid   = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        check("coll_we_waddr", {26'd0, we, waddr}, {26'd0, 1'b1, 5'd9});
        tick();
        issue_valid = 1'b0;
        check("coll_f9", pending[9], 1);

        // Clear f9, then build pending = 0xF0.
        req_valid = 3'b001;
        tick();
        req_valid   = '0;
        issue_valid = 1'b1;
        for (int r = 4; r < 8; r++) begin
            issue_rd = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        check("pre_flush", pending, 32'h0000_00F0);

        // Flush squashes a grant and an issue in the same cycle.
        req_valid   = 3'b001;
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        req_valid   = '0;
        check("flush_we", we, 0);
        check("flush_pending", pending, 0);

        // Pointer survives flush; then reset mid-stream restarts the order at 0.
        req_valid   = '1;
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        tick();
        issue_rd = 5'd13;
        tick();
        issue_valid = 1'b0;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_we", we, 0);
        check("rst_pending", pending, 0);
        #1;
        check("restart_grant", req_ready, 3'b001);
        repeat (3) tick();
        req_valid = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
